// File: rtl/csa_seq_mac_pkg.sv
// Shared types and helpers for the sequential carry-save multiply-accumulate unit.
package csa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Step counter width; never below one bit so the counter always exists.
  function automatic int cnt_w(input int width, input int step);
    return (width / step <= 1) ? 1 : $clog2(width / step);
  endfunction

endpackage

// File: rtl/csa_seq_mac_row.sv
// One N-bit row of 3:2 compressors; carry is returned already shifted by one place.
module csa_row #(
  parameter int N = 17
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  logic [N-2:0] maj;

  assign sum   = x ^ y ^ z;
  // The top majority bit would shift out of the row, so it is never formed.
  assign maj   = (x[N-2:0] & y[N-2:0]) | (x[N-2:0] & z[N-2:0]) | (y[N-2:0] & z[N-2:0]);
  assign carry = {maj, 1'b0};

endmodule

// File: rtl/csa_seq_mac.sv
// Sequential unsigned MAC: P = A*B + ACC, STEP multiplier bits per cycle through
// chained carry-save rows, one carry-propagate add at the end.
module csa_seq_mac
  import csa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 acc_en,
  input  logic [2*WIDTH-1:0]   acc_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 ovf
);

  localparam int DW   = 2 * WIDTH + 1;
  localparam int NGRP = WIDTH / STEP;
  localparam int CW   = cnt_w(WIDTH, STEP);
  localparam logic [CW-1:0] CNT_LAST = CW'(NGRP - 1);

  if (STEP < 1 || STEP > 2 || (WIDTH % STEP) != 0 || WIDTH < 4 || WIDTH > 32) begin : g_bad_cfg
    $error("csa_seq_mac: illegal WIDTH/STEP combination");
  end

  state_e                     state_q, state_d;
  logic [WIDTH-1:0]           a_q, a_d, b_q, b_d;
  logic [DW-1:0]              s_q, s_d, c_q, c_d, r;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [2*WIDTH-1:0]         p_q, p_d;
  logic                       ovf_q, ovf_d;

  logic [CW:0]                shamt;
  logic [STEP-1:0]            bgrp;
  logic [DW-1:0]              a_ext;
  logic [STEP-1:0][DW-1:0]    pp;
  logic [STEP:0][DW-1:0]      s_ch, c_ch;

  // Bit position of the first multiplier bit retired this cycle.
  assign shamt = (STEP == 2) ? {cnt_q, 1'b0} : {1'b0, cnt_q};
  assign bgrp  = STEP'(b_q >> shamt);
  assign a_ext = {{(WIDTH+1){1'b0}}, a_q};

  always_comb begin
    pp = '0;
    for (int k = 0; k < STEP; k++) begin
      pp[k] = bgrp[k] ? ((a_ext << shamt) << k) : '0;
    end
  end

  assign s_ch[0] = s_q;
  assign c_ch[0] = c_q;

  for (genvar g = 0; g < STEP; g++) begin : g_row
    csa_row #(.N(DW)) u_row (
      .x     (s_ch[g]),
      .y     (c_ch[g]),
      .z     (pp[g]),
      .sum   (s_ch[g+1]),
      .carry (c_ch[g+1])
    );
  end

  assign r = s_q + c_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          s_d     = acc_en ? {1'b0, acc_in} : '0;
          c_d     = '0;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        s_d   = s_ch[STEP];
        c_d   = c_ch[STEP];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        p_d     = r[2*WIDTH-1:0];
        ovf_d   = r[DW-1];
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign p         = p_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_csa_seq_mac.sv
// Scoreboard bench for csa_seq_mac: three configurations (8/1, 8/2, 16/1),
// stimulus pushes expected {ovf,p}, per-DUT monitors pop on each handshake.
module tb_csa_seq_mac;

  logic clk = 1'b0;
  logic rst_n, rst_g;

  logic iv0, ir0, ae0, ov0, or0, f0;
  logic [7:0]  a0, b0;
  logic [15:0] acc0, p0;

  logic iv1, ir1, ae1, ov1, or1, f1;
  logic [7:0]  a1, b1;
  logic [15:0] acc1, p1;

  logic iv2, ir2, ae2, ov2, or2, f2;
  logic [15:0] a2, b2;
  logic [31:0] acc2, p2;

  int errs = 0;
  int checks = 0;
  logic [32:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  csa_seq_mac #(.WIDTH(8), .STEP(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .acc_en(ae0), .acc_in(acc0), .out_valid(ov0), .out_ready(or0), .p(p0), .ovf(f0));

  csa_seq_mac #(.WIDTH(8), .STEP(2)) dut1 (
    .clk(clk), .rst_n(rst_g), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .acc_en(ae1), .acc_in(acc1), .out_valid(ov1), .out_ready(or1), .p(p1), .ovf(f1));

  csa_seq_mac #(.WIDTH(16), .STEP(1)) dut2 (
    .clk(clk), .rst_n(rst_g), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .acc_en(ae2), .acc_in(acc2), .out_valid(ov2), .out_ready(or2), .p(p2), .ovf(f2));

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: compare every accepted result against the oldest expectation.
  always @(negedge clk) begin
    if (ov0 && or0) begin
      if (q0.size() == 0) begin
        checks++; errs++;
        $display("FAIL dut0 unexpected result: got %h expected none", {f0, p0});
      end else chk("dut0 result", {16'b0, f0, p0}, q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (ov1 && or1) begin
      if (q1.size() == 0) begin
        checks++; errs++;
        $display("FAIL dut1 unexpected result: got %h expected none", {f1, p1});
      end else chk("dut1 result", {16'b0, f1, p1}, q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (ov2 && or2) begin
      if (q2.size() == 0) begin
        checks++; errs++;
        $display("FAIL dut2 unexpected result: got %h expected none", {f2, p2});
      end else chk("dut2 result", {f2, p2}, q2.pop_front());
    end
  end

  function automatic logic rdy(input int d);
    case (d)
      0:       return ir0;
      1:       return ir1;
      default: return ir2;
    endcase
  endfunction

  function automatic logic vld(input int d);
    case (d)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  task automatic drive(input int d, input logic [15:0] a, input logic [15:0] b,
                       input logic en, input logic [31:0] acc, input logic v);
    case (d)
      0: begin iv0 = v; a0 = a[7:0]; b0 = b[7:0]; ae0 = en; acc0 = acc[15:0]; end
      1: begin iv1 = v; a1 = a[7:0]; b1 = b[7:0]; ae1 = en; acc1 = acc[15:0]; end
      default: begin iv2 = v; a2 = a; b2 = b; ae2 = en; acc2 = acc; end
    endcase
  endtask

  task automatic push(input int d, input logic [32:0] exp);
    case (d)
      0:       q0.push_back(exp);
      1:       q1.push_back(exp);
      default: q2.push_back(exp);
    endcase
  endtask

  // Present one operand set, then scramble inputs after acceptance and
  // measure edges from accept until out_valid is seen.
  task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b,
                       input logic en, input logic [31:0] acc, input logic [32:0] exp,
                       input int exp_lat, input string name);
    int n;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!rdy(d) && n < 100);
    if (!rdy(d)) begin
      checks++; errs++;
      $display("FAIL %s in_ready timeout: got 0 expected 1", name);
      return;
    end
    drive(d, a, b, en, acc, 1'b1);
    push(d, exp);
    @(posedge clk); #1;
    drive(d, ~a, ~b, ~en, ~acc, 1'b0);
    n = 0;
    while (!vld(d) && n < 100) begin @(posedge clk); #1; n++; end
    chk({name, " latency"}, 33'(n), 33'(exp_lat));
  endtask

  initial begin
    int seen, first_v, second_acc;
    logic [15:0] ra, rb;
    logic [31:0] racc;
    logic        ren;
    logic [32:0] e;

    rst_n = 1'b0; rst_g = 1'b0;
    drive(0, 16'h0, 16'h0, 1'b0, 32'h0, 1'b0);
    drive(1, 16'h0, 16'h0, 1'b0, 32'h0, 1'b0);
    drive(2, 16'h0, 16'h0, 1'b0, 32'h0, 1'b0);
    or0 = 1'b1; or1 = 1'b1; or2 = 1'b1;
    #22 rst_n = 1'b1; rst_g = 1'b1;
    #1;
    chk("reset in_ready",  33'(ir0), 33'd1);
    chk("reset out_valid", 33'(ov0), 33'd0);
    chk("reset p",         33'(p0),  33'd0);
    chk("reset ovf",       33'(f0),  33'd0);

    // WIDTH=8, STEP=1 directed vectors
    issue(0, 16'h0F, 16'h0F, 1'b0, 32'h0,     33'h000E1, 9, "0F*0F");
    issue(0, 16'hFF, 16'hFF, 1'b0, 32'h0,     33'h0FE01, 9, "FF*FF");
    issue(0, 16'hFF, 16'hFF, 1'b1, 32'hFFFF,  33'h1FE00, 9, "FF*FF+FFFF");
    issue(0, 16'h12, 16'h34, 1'b0, 32'hFFFF,  33'h003A8, 9, "acc_en=0 ignores acc_in");
    issue(0, 16'hA5, 16'h00, 1'b0, 32'h0,     33'h00000, 9, "A5*00");

    // Backpressure: result and handshake state held while out_ready is low
    @(posedge clk); #1 or0 = 1'b0;
    issue(0, 16'h00, 16'hA5, 1'b1, 32'h1234, 33'h01234, 9, "00*A5+1234");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("backpressure out_valid", 33'(ov0), 33'd1);
      chk("backpressure p",         33'(p0),  33'h1234);
      chk("backpressure in_ready",  33'(ir0), 33'd0);
    end
    or0 = 1'b1;
    @(posedge clk); #1;
    chk("release out_valid", 33'(ov0), 33'd0);
    chk("release in_ready",  33'(ir0), 33'd1);

    // Asynchronous reset in the middle of ACCUM; aborted op never completes
    @(posedge clk); #1;
    drive(0, 16'h7B, 16'h3C, 1'b0, 32'h0, 1'b1);
    @(posedge clk); #1;
    drive(0, 16'h0, 16'h0, 1'b0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async reset in_ready",  33'(ir0), 33'd1);
    chk("async reset out_valid", 33'(ov0), 33'd0);
    chk("async reset p",         33'(p0),  33'd0);
    chk("async reset ovf",       33'(f0),  33'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ov0) seen++;
    end
    chk("no stale result after reset", 33'(seen), 33'd0);
    issue(0, 16'h03, 16'h05, 1'b0, 32'h0, 33'h0000F, 9, "03*05 after reset");

    // Back-to-back with in_valid held high through the first operation
    @(posedge clk); #1;
    drive(0, 16'h11, 16'h22, 1'b0, 32'h0, 1'b1);
    push(0, 33'h00242);
    @(posedge clk); #1;
    drive(0, 16'h0A, 16'h0B, 1'b1, 32'h0100, 1'b1);
    push(0, 33'h0016E);
    first_v = -1; second_acc = -1;
    for (int n = 1; n <= 30 && second_acc < 0; n++) begin
      @(posedge clk); #1;
      if (ov0 && first_v < 0) first_v = n;
      if (first_v >= 0 && n > first_v && !ir0 && !ov0) begin
        second_acc = n;
        drive(0, 16'h0, 16'h0, 1'b0, 32'h0, 1'b0);
      end
    end
    drive(0, 16'h0, 16'h0, 1'b0, 32'h0, 1'b0);
    chk("b2b first latency", 33'(first_v), 33'd9);
    chk("b2b accept gap",    33'(second_acc - first_v), 33'd2);
    seen = 0;
    while (!ov0 && seen < 50) begin @(posedge clk); #1; seen++; end
    chk("b2b second latency", 33'(seen), 33'd9);

    // WIDTH=8, STEP=2: directed then reference-model random triples
    issue(1, 16'h0F, 16'h0F, 1'b0, 32'h0,    33'h000E1, 5, "s2 0F*0F");
    issue(1, 16'hFF, 16'hFF, 1'b1, 32'hFFFF, 33'h1FE00, 5, "s2 FF*FF+FFFF");
    issue(1, 16'h00, 16'hA5, 1'b1, 32'h1234, 33'h01234, 5, "s2 00*A5+1234");
    issue(1, 16'h80, 16'h01, 1'b0, 32'h0,    33'h00080, 5, "s2 80*01");
    for (int i = 0; i < 1000; i++) begin
      ra   = 16'($urandom_range(0, 255));
      rb   = 16'($urandom_range(0, 255));
      racc = 32'($urandom_range(0, 65535));
      ren  = 1'($urandom_range(0, 1));
      e    = 33'(ra) * 33'(rb) + (ren ? 33'(racc) : 33'd0);
      issue(1, ra, rb, ren, racc, e, 5, "s2 random");
    end

    // WIDTH=16, STEP=1
    issue(2, 16'hFFFF, 16'hFFFF, 1'b0, 32'h0,        33'h0FFFE0001, 17, "w16 FFFF*FFFF");
    issue(2, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFFFFFF, 33'h1FFFE0000, 17, "w16 FFFF*FFFF+max");

    repeat (5) @(posedge clk);
    #1;
    chk("dut0 queue drained", 33'(q0.size()), 33'd0);
    chk("dut1 queue drained", 33'(q1.size()), 33'd0);
    chk("dut2 queue drained", 33'(q2.size()), 33'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
